// File: rtl/fpu_link_pkg.sv
// Shared definitions for the FPU <-> host serial link.
// Used by fpu_result_tx (FPU -> host) and by the host -> FPU operand receiver.
// Contents: frame header/length constants, opcode encodings, byte-serializer
// state enum and the frame checksum helper.
package fpu_link_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam int         FRAME_BYTES = 7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // XOR of every frame byte after the header (opcode byte + 4 result bytes).
    function automatic logic [7:0] frame_checksum(input logic [1:0]  op,
                                                  input logic [31:0] res);
        return {6'b0, op} ^ res[7:0] ^ res[15:8] ^ res[23:16] ^ res[31:24];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer, LSB first.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   byte handshake; ready is combinational so the next byte
//                    can be taken on the final cycle of a stop bit (no gap)
//   data             byte to send, sampled on the handshake edge
//   tx               registered UART line, idles high
module uart_tx_byte
    import fpu_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data,
    output logic       tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end  = (timer == T_LAST);
    // Ready on the last cycle of a stop bit lets the next start bit follow
    // immediately.
    assign in_ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (in_valid) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= shreg[0];
                        state <= TX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            // bit 0 of shreg is on the line; present the next one
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (in_valid) begin
                            shreg <= data;
                            tx    <= 1'b0;
                            state <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpu_result_tx.sv
// FPU result transmitter: takes one result + opcode over valid/ready and sends
// the 7-byte frame A5, {6'b0,op}, res[7:0..31:24], checksum as 8N1 UART.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready result handshake; in_ready is low for the whole frame
//   opcode, result    captured on the handshake edge
//   tx                UART line, idles high
//   busy              frame in progress (== !in_ready)
module fpu_result_tx
    import fpu_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  opcode,
    input  logic [31:0] result,
    output logic        tx,
    output logic        busy
);

    logic        busy_q;
    logic [1:0]  op_q;
    logic [31:0] res_q;
    logic [7:0]  chk_q;
    logic [2:0]  byte_idx;   // index of the byte currently on the line

    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        take;
    logic        last_byte;

    assign take      = in_valid && !busy_q;
    assign last_byte = (byte_idx == 3'(FRAME_BYTES - 1));
    assign in_ready  = !busy_q;
    assign busy      = busy_q;

    // While idle the header goes straight to the serializer on the capture
    // edge, so the start bit appears the cycle after the transfer. While busy,
    // offer byte_idx+1 for hand-off at the end of the current stop bit.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = FRAME_HDR;
        if (!busy_q) begin
            byte_valid = in_valid;
        end else begin
            byte_valid = !last_byte;
            case (byte_idx)
                3'd0:    byte_data = {6'b0, op_q};
                3'd1:    byte_data = res_q[7:0];
                3'd2:    byte_data = res_q[15:8];
                3'd3:    byte_data = res_q[23:16];
                3'd4:    byte_data = res_q[31:24];
                default: byte_data = chk_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            byte_idx <= '0;
            op_q     <= '0;
            res_q    <= '0;
            chk_q    <= '0;
        end else if (take) begin
            busy_q   <= 1'b1;
            byte_idx <= '0;
            op_q     <= opcode;
            res_q    <= result;
            chk_q    <= frame_checksum(opcode, result);
        end else if (busy_q && byte_ready) begin
            // serializer is finishing a stop bit this cycle
            if (last_byte) begin
                busy_q   <= 1'b0;
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .in_valid (byte_valid),
        .in_ready (byte_ready),
        .data     (byte_data),
        .tx       (tx)
    );

endmodule

// File: tb/tb_fpu_result_tx.sv
module tb_fpu_result_tx;
    import fpu_link_pkg::*;

    localparam int CPB   = 4;
    localparam int FRAME = 70 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  opcode;
    logic [31:0] result;
    logic        in_ready, tx, busy;

    always #5 clk = ~clk;

    fpu_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .result   (result),
        .tx       (tx),
        .busy     (busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] res;
        logic [55:0] frame;   // byte 0 in [55:48]
    } vec_t;

    vec_t       vt [0:5];
    logic [7:0] sb [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         epoch = 0;
    bit         chk_busy = 1'b0;

    always @(negedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_busy && (busy !== !in_ready)) begin
            n_err++;
            $display("FAIL busy_vs_ready busy=%b in_ready=%b at cycle %0d", busy, in_ready, cyc);
        end
    end

    // UART monitor: samples each bit mid-period, compares against scoreboard.
    logic [7:0] m_b, m_exp;
    logic       m_ok;
    int         m_ep;
    always begin
        @(negedge clk);
        if (tx === 1'b0) begin
            m_ep = epoch;
            m_ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) m_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                m_b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) m_ok = 1'b0;
            if (m_ep == epoch) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL uart_byte unexpected byte %02h", m_b);
                end else begin
                    m_exp = sb.pop_front();
                    if (!m_ok || m_b !== m_exp) begin
                        n_err++;
                        $display("FAIL uart_byte got %02h framing_ok=%0b required %02h", m_b, m_ok, m_exp);
                    end
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %b required %b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [55:0] f);
        for (int i = 0; i < 7; i++) sb.push_back(f[55 - 8*i -: 8]);
    endtask

    // Waits (bounded) for in_ready, presents vector vi for exactly one edge.
    task automatic send(input int vi, output int kc);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        kc = cyc;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready vec %0d in_ready=%b required 1", vi, in_ready);
            return;
        end
        opcode   = vt[vi].op;
        result   = vt[vi].res;
        in_valid = 1'b1;
        @(posedge clk);
        push_frame(vt[vi].frame);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chkn(nm, sb.size(), 0);
    endtask

    initial begin
        int k, k1, k2, n, caps, cap2_i, lows, nready;
        vt[0] = '{OP_ADD, 32'h40A00000, 56'hA5_00_00_00_A0_40_E0};
        vt[1] = '{OP_SUB, 32'hBF800000, 56'hA5_01_00_00_80_BF_3E};
        vt[2] = '{OP_MUL, 32'h40C00000, 56'hA5_02_00_00_C0_40_82};
        vt[3] = '{OP_DIV, 32'h3F2AAAAB, 56'hA5_03_AB_AA_2A_3F_17};
        vt[4] = '{OP_ADD, 32'h11223344, 56'hA5_00_44_33_22_11_44};
        vt[5] = '{OP_SUB, 32'hFFFFFFFF, 56'hA5_01_FF_FF_FF_FF_01};

        // Reset with in_valid asserted: must be ignored.
        rst = 1'b1; in_valid = 1'b1; opcode = OP_DIV; result = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk1("reset_tx", tx, 1'b1);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        chk_busy = 1'b1;
        lows = 0;
        repeat (20) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        chkn("post_reset_tx_low_cycles", lows, 0);

        // Table-driven single frames with ready-low length check.
        for (int i = 0; i < 2; i++) begin
            int vi;
            vi = (i == 0) ? 0 : 5;
            send(vi, k);
            n = 0;
            @(negedge clk);
            chk1("start_bit_immediate", tx, 1'b0);
            while (in_ready !== 1'b1 && n < 400) begin
                n++;
                @(negedge clk);
            end
            chkn("ready_low_cycles", n, FRAME);
            wait_drain("frame_drain");
        end

        // Back-to-back: second transfer in the first ready cycle.
        send(1, k1);
        send(2, k2);
        chkn("b2b_spacing", k2 - k1, FRAME + 1);
        wait_drain("b2b_drain");

        // Held valid with inputs changed mid-frame.
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        opcode = vt[3].op; result = vt[3].res; in_valid = 1'b1;
        caps = 0; cap2_i = -1;
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin opcode = vt[4].op; result = vt[4].res; end
            if (in_ready === 1'b1) begin
                caps++;
                if (caps == 2) cap2_i = i;
                push_frame((i < 100) ? vt[3].frame : vt[4].frame);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chkn("held_capture_count", caps, 2);
        chkn("held_second_capture_cycle", cap2_i, FRAME + 1);
        wait_drain("held_drain");

        // Reset in the middle of byte 3.
        send(1, k);
        repeat (130) @(negedge clk);
        rst = 1'b1;
        epoch++;
        sb.delete();
        @(negedge clk);
        chk1("midreset_tx", tx, 1'b1);
        chk1("midreset_in_ready", in_ready, 1'b1);
        chk1("midreset_busy", busy, 1'b0);
        rst = 1'b0;
        lows = 0;
        repeat (100) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        chkn("midreset_no_bits", lows, 0);
        send(5, k);
        wait_drain("post_reset_frame_drain");

        // Long idle.
        repeat (2 * CPB) @(negedge clk);
        lows = 0; nready = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (in_ready !== 1'b1) nready++;
        end
        chkn("idle_tx_low_cycles", lows, 0);
        chkn("idle_not_ready_cycles", nready, 0);
        chkn("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
